// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor: controller
// state encoding and the width of the single reused add slice.
package serial_adder_ctrl_pkg;

  // Width of one add slice; operands are processed this many bits per cycle.
  localparam int SLICE_W = 4;

  // Controller states: waiting for start, stepping through slices, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_adder_ctrl_pkg

// File: rtl/serial_adder_ctrl_nibble_adder.sv
// Purely combinational 4-bit add slice. Besides the slice sum and carry out,
// it exposes the carry into its MSB so the controller can derive signed
// overflow when this slice is the top nibble of the operand.
module nibble_adder
  import serial_adder_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co,
  output logic               c_msb
);

  // Lower bits plus carry-in; the top bit of this sum is the carry into the MSB.
  logic [SLICE_W-1:0] low_sum;
  // MSB column: x, y and the carry coming out of the lower bits.
  logic [1:0]         msb_sum;

  assign low_sum = {1'b0, x[SLICE_W-2:0]} + {1'b0, y[SLICE_W-2:0]}
                 + {{(SLICE_W-1){1'b0}}, ci};
  assign msb_sum = {1'b0, x[SLICE_W-1]} + {1'b0, y[SLICE_W-1]}
                 + {1'b0, low_sum[SLICE_W-1]};

  assign s     = {msb_sum[0], low_sum[SLICE_W-2:0]};
  assign co    = msb_sum[1];
  assign c_msb = low_sum[SLICE_W-1];

endmodule : nibble_adder

// File: rtl/serial_adder_ctrl.sv
// Nibble-serial adder/subtractor. A start in IDLE latches the operands and
// the operation; one shared 4-bit slice then processes one nibble per cycle,
// LSB first, threading the carry through a register. Subtraction is a + ~b + 1,
// with the +1 supplied by preloading the carry. The result is flagged by a
// single-cycle done pulse; sum is only meaningful while qualified by done.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = SLICE_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  // Slice index needs at least one bit even for a single-nibble instance.
  localparam int                IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic               carry_q, carry_d;
  logic               sub_q,   sub_d;
  logic [W-1:0]       a_q,     a_d;
  logic [W-1:0]       b_q,     b_d;
  logic [W-1:0]       sum_q,   sum_d;
  logic               cout_q,  cout_d;
  logic               ovf_q,   ovf_d;

  // Operands for the nibble currently selected by the index.
  logic [SLICE_W-1:0] slice_x;
  logic [SLICE_W-1:0] slice_y;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_co;
  logic               slice_cmsb;

  assign slice_x = a_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_y = b_q[idx_q*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_q}};

  nibble_adder u_slice (
    .x     (slice_x),
    .y     (slice_y),
    .ci    (carry_q),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_cmsb)
  );

  // Next-state logic: accept in IDLE, step one nibble per cycle in RUN, pulse in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = op_sub;
          carry_d = op_sub;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = slice_s;
        carry_d = slice_co;
        if (idx_q == LAST_IDX) begin
          // Top nibble: its carries give the unsigned carry and signed overflow.
          cout_d  = slice_co;
          ovf_d   = slice_co ^ slice_cmsb;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: a default 4-nibble instance exercised with
// directed and random operations, and a 1-nibble instance swept exhaustively.
// Expected results come from an integer-arithmetic model of add/subtract.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 4-nibble instance
  logic        start4 = 1'b0;
  logic        sub4   = 1'b0;
  logic [15:0] a4     = '0;
  logic [15:0] b4     = '0;
  logic        busy4, done4, cout4, ovf4;
  logic [15:0] sum4;

  // 1-nibble instance
  logic        start1 = 1'b0;
  logic        sub1   = 1'b0;
  logic [3:0]  a1     = '0;
  logic [3:0]  b1     = '0;
  logic        busy1, done1, cout1, ovf1;
  logic [3:0]  sum1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op_sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  serial_adder_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Integer reference: w-bit add or subtract, unsigned carry (no-borrow for
  // subtract) and signed overflow judged by the true signed result range.
  task automatic ref_model(input int w, input int a, input int b, input bit sub,
                           output int s, output bit co, output bit ov);
    int mask, ua, ub, sa, sb, r, full;
    mask = (1 << w) - 1;
    ua = a & mask;
    ub = b & mask;
    if (sub) begin
      co = (ua >= ub);
      s  = (ua - ub) & mask;
    end else begin
      full = ua + ub;
      co = (full > mask);
      s  = full & mask;
    end
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    r  = sub ? sa - sb : sa + sb;
    ov = (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
  endtask

  task automatic run4(input logic [15:0] a, input logic [15:0] b, input bit sub);
    int s, cyc;
    bit co, ov, seen;
    ref_model(16, int'(a), int'(b), sub, s, co, ov);
    @(negedge clk);
    a4 = a; b4 = b; sub4 = sub; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    a4 = 16'($urandom); b4 = 16'($urandom); sub4 = 1'($urandom);
    check("busy_run", 32'(busy4), 1);
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 1);
    check("latency", 32'(cyc), 5);
    check("sum", 32'(sum4), 32'(s));
    check("cout", 32'(cout4), 32'(co));
    check("ovf", 32'(ovf4), 32'(ov));
    check("busy_done", 32'(busy4), 0);
    @(negedge clk);
    check("done_pulse", 32'(done4), 0);
    check("sum_hold", 32'(sum4), 32'(s));
    $display("op4 a=%h b=%h sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             a, b, sub, sum4, cout4, ovf4, cyc);
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b, input bit sub);
    int s, cyc;
    bit co, ov, seen;
    ref_model(4, int'(a), int'(b), sub, s, co, ov);
    @(negedge clk);
    a1 = a; b1 = b; sub1 = sub; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    a1 = 4'($urandom); b1 = 4'($urandom); sub1 = 1'($urandom);
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 10) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (done1) seen = 1'b1;
    end
    check("n1_latency", 32'(cyc), 2);
    check("n1_result", {29'd0, ovf1, cout1, sum1}, {29'd0, ov, co, 4'(s)});
    $display("op1 a=%h b=%h sub=%0d -> sum=%h cout=%0d ovf=%0d", a, b, sub, sum1, cout1, ovf1);
  endtask

  initial begin
    int pulses;
    logic [15:0] sum_at_done;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy4), 0);
    check("rst_done", 32'(done4), 0);
    check("rst_sum", 32'(sum4), 0);
    check("rst_cout", 32'(cout4), 0);
    check("rst_ovf", 32'(ovf4), 0);
    check("rst_n1", {27'd0, busy1, done1, sum1 == 4'd0 ? 1'b0 : 1'b1, cout1, ovf1}, 0);

    // Directed corner operations
    run4(16'h1234, 16'h4321, 1'b0);
    run4(16'hFFFF, 16'h0001, 1'b0);
    run4(16'h7FFF, 16'h0001, 1'b0);
    run4(16'h0005, 16'h0007, 1'b1);
    run4(16'h8000, 16'h0001, 1'b1);
    run4(16'h1234, 16'h0000, 1'b1);

    // Second start while busy must be ignored
    @(negedge clk);
    a4 = 16'h1111; b4 = 16'h2222; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk); @(negedge clk); start4 = 1'b0;
    @(posedge clk); @(negedge clk);
    a4 = 16'hAAAA; b4 = 16'h5555; sub4 = 1'b1; start4 = 1'b1;
    @(posedge clk); @(negedge clk); start4 = 1'b0;
    pulses = 0; sum_at_done = '0;
    for (int i = 0; i < 15; i++) begin
      if (done4) begin pulses++; sum_at_done = sum4; end
      @(posedge clk); @(negedge clk);
    end
    check("busy_pulses", 32'(pulses), 1);
    check("busy_sum", 32'(sum_at_done), 32'h3333);
    check("busy_idle", 32'(busy4), 0);
    $display("busy-start test: pulses=%0d sum=%h", pulses, sum_at_done);

    // Reset during the second RUN cycle aborts without a done pulse
    @(negedge clk);
    a4 = 16'h0F0F; b4 = 16'h0101; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk); @(negedge clk); start4 = 1'b0;
    @(posedge clk); @(negedge clk); rst = 1'b1;
    @(posedge clk); @(negedge clk); rst = 1'b0;
    check("abort_busy", 32'(busy4), 0);
    check("abort_done", 32'(done4), 0);
    check("abort_sum", 32'(sum4), 0);
    check("abort_flags", {30'd0, cout4, ovf4}, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (done4) pulses++;
    end
    check("abort_nodone", 32'(pulses), 0);
    $display("reset-abort test: pulses=%0d", pulses);
    run4(16'h0F0F, 16'h0101, 1'b0);

    // Random operations
    for (int i = 0; i < 40; i++)
      run4(16'($urandom), 16'($urandom), 1'($urandom));

    // Exhaustive single-nibble sweep
    for (int sb = 0; sb < 2; sb++)
      for (int xa = 0; xa < 16; xa++)
        for (int xb = 0; xb < 16; xb++)
          run1(4'(xa), 4'(xb), sb[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_adder_ctrl

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand.
REQ-002 The block SHALL derive localparam W = 4*NIBBLES as the operand width; W is not overridable.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-006 Port op_sub, input, 1 bit: 0 selects a+b, 1 selects a-b; sampled with start.
REQ-007 Port a, input, W bits: first operand, unsigned or two's complement.
REQ-008 Port b, input, W bits: second operand.
REQ-009 Port busy, output, 1 bit: high while an operation is in progress (RUN state).
REQ-010 Port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-011 Port sum, output, W bits: the result, held until the next accepted start or reset.
REQ-012 Port cout, output, 1 bit: carry out of the MSB slice; for subtract, 1 means no borrow.
REQ-013 Port ovf, output, 1 bit: signed overflow of the W-bit result.

Function
REQ-014 The block SHALL implement three states, IDLE, RUN and DONE, with one shared 4-bit adder slice reused each cycle.
REQ-015 In IDLE with start=1, the block SHALL latch a, b and op_sub, preload the carry with op_sub, clear the slice index, and go to RUN on the next edge.
REQ-016 In IDLE with start=0, the block SHALL remain in IDLE with all outputs held.
REQ-017 In RUN at slice index i, the slice SHALL add a[4i+3:4i], (b[4i+3:4i] XOR {4{op_sub}}) and the carry register.
REQ-018 The slice sum SHALL be written into sum[4i+3:4i], and the slice carry SHALL be stored in the carry register.
REQ-019 The slice index SHALL increment by one per cycle; after slice NIBBLES-1 is processed, the block SHALL go to DONE.
REQ-020 In DONE, the block SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-021 In DONE, cout SHALL equal the final carry and ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-022 Latency: if start is sampled at edge k, done SHALL be high in the cycle after edge k+NIBBLES, i.e. NIBBLES+1 edges after start for the default.
REQ-023 start SHALL be ignored in RUN and DONE, so no queuing and no corruption of latched operands occurs.
REQ-024 Changes on a, b or op_sub after acceptance SHALL NOT affect the result in progress.
REQ-025 sum SHALL be modulo 2^W; wrap-around SHALL be reported only via cout and ovf.
REQ-026 Partially written sum bits SHALL be visible during RUN, and consumers SHALL qualify sum with done.
REQ-027 The minimum spacing between accepted starts SHALL be NIBBLES+2 cycles, since start is accepted only in IDLE.

Reset
REQ-028 On rst=1 at a clock edge, the state SHALL become IDLE.
REQ-029 On reset, busy, done, sum, cout and ovf SHALL become 0, and the carry and index registers SHALL become 0.
REQ-030 Reset SHALL take priority over start and over an operation in progress; an aborted operation SHALL NOT produce a done pulse.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, RUN, DONE) and the slice width constant 4.
REQ-032 The 4-bit add slice SHALL be a separate purely combinational sub-module named nibble_adder (inputs x[3:0], y[3:0], ci; outputs s[3:0], co), with carry-into-MSB exposed or computed locally for ovf.
REQ-033 The controller SHALL hold all registers, and nibble_adder SHALL hold none.

Verification
REQ-034 Scenario add: a=0x1234, b=0x4321, op_sub=0, start pulse -> done after 5 edges, sum=0x5555, cout=0, ovf=0.
REQ-035 Scenario carry wrap: a=0xFFFF, b=0x0001, add -> sum=0x0000, cout=1, ovf=0; and a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-036 Scenario subtract: a=0x0005, b=0x0007, op_sub=1 -> sum=0xFFFE, cout=0 (borrow); and a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.
REQ-037 Scenario start during busy: second start with different operands two cycles after the first -> only the first result is produced, with exactly one done pulse.
REQ-038 Scenario reset mid-run: rst=1 during the second RUN cycle -> next cycle state IDLE, all outputs 0, no done pulse; a fresh start afterwards completes correctly.
REQ-039 Scenario exhaustive slice: an NIBBLES=1 instance swept over all 16x16x2 combinations of a, b and op_sub -> each result matches a reference model.
